// File: rtl/waves_pkg.sv
// Shared definitions for the tt_um_waves UART link: line-rate defaults and
// the transmitter state encoding.
package waves_pkg;

  localparam int UART_CLK_FREQ = 25_000_000;
  localparam int UART_BAUD     = 9600;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous byte FIFO; the head entry is visible combinationally on
// rdata so the consumer can pop and capture it on the same edge.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [7:0]             wdata,
  output logic [7:0]             rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;

  // NOTE: default first so every path assigns count_d and no latch is inferred.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // NOTE: storage is not reset; count_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter fed by a byte FIFO; frames go back to back whenever
// the FIFO still holds data at the end of a stop bit.
module uart_tx
  import waves_pkg::*;
#(
  parameter int CLK_FREQ   = UART_CLK_FREQ,
  parameter int BAUD       = UART_BAUD,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int BCW          = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CNT_W        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BCW-1:0]   BAUD_LAST = BCW'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);

  uart_tx_state_t state_q;
  logic [BCW-1:0] baud_q;
  logic [2:0]     bit_idx_q;
  logic [7:0]     shift_q;
  logic           tx_q;

  logic           fifo_empty;
  logic           bit_end;
  logic           push;
  logic           pop;
  logic [7:0]     fifo_head;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (tx_data),
    .rdata (fifo_head),
    .count (fifo_count)
  );

  assign fifo_empty = (fifo_count == '0);
  assign bit_end    = (baud_q == BAUD_LAST);
  assign tx_ready   = (fifo_count != FIFO_FULL);
  assign push       = tx_valid && tx_ready;
  // A new frame is loaded from idle or straight out of a finished stop bit.
  assign pop        = !fifo_empty && ((state_q == IDLE) || ((state_q == STOP) && bit_end));
  assign busy       = (state_q != IDLE) || !fifo_empty;
  assign tx         = tx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q <= fifo_head;
            baud_q  <= '0;
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            tx_q      <= shift_q[0];
            state_q   <= DATA;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_q <= '0;
            if (bit_idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              shift_q   <= {1'b0, shift_q[7:1]};
              bit_idx_q <= bit_idx_q + 1'b1;
              tx_q      <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_q <= '0;
            if (pop) begin
              shift_q <= fifo_head;
              tx_q    <= 1'b0;
              state_q <= START;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a frame-level model predicts every output
// each cycle, and a line decoder recovers bytes for order checks.
module tb_uart_tx;

  localparam int CLK_FREQ = 160;
  localparam int BAUD     = 10;
  localparam int DEPTH    = 4;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int FRAME    = 10 * CPB;
  localparam int LIMIT    = (DEPTH + 2) * FRAME;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;

  uart_tx #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame-level model: a byte queue plus the time elapsed in the current frame.
  logic [7:0] m_q[$];
  logic [7:0] m_cur;
  int         m_t;
  bit         m_active;
  int         m_old;
  bit         m_acc;
  bit         m_pop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_active = 1'b0;
      m_t      = 0;
    end else begin
      m_old = m_q.size();
      m_acc = tx_valid && (m_old != DEPTH);
      m_pop = (m_old > 0) && (!m_active || (m_t == FRAME - 1));
      if (m_pop) begin
        m_cur    = m_q.pop_front();
        m_active = 1'b1;
        m_t      = 0;
      end else if (m_active) begin
        if (m_t == FRAME - 1) m_active = 1'b0;
        else                  m_t++;
      end
      if (m_acc) m_q.push_back(tx_data);
    end
  end

  function automatic logic exp_tx();
    int b;
    if (!m_active) return 1'b1;
    b = m_t / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_cur[b-1];
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("tx", tx, exp_tx());
      check("tx_ready", tx_ready, m_q.size() != DEPTH);
      check("busy", busy, m_active || (m_q.size() != 0));
      check("fifo_count", fifo_count, m_q.size());
    end
  end

  // Line decoder: samples each bit at its midpoint.
  logic [7:0] rx_q[$];
  bit         d_busy;
  int         d_c;
  int         d_k;
  logic [7:0] d_sh;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_busy = 1'b0;
      d_c    = 0;
    end else if (!d_busy) begin
      if (tx === 1'b0) begin
        d_busy = 1'b1;
        d_c    = 0;
      end
    end else begin
      d_c++;
      if (d_c % CPB == CPB / 2) begin
        d_k = d_c / CPB;
        if (d_k == 0) begin
          check("start_bit", tx, 1'b0);
        end else if (d_k <= 8) begin
          d_sh[3'(d_k-1)] = tx;
        end else begin
          check("stop_bit", tx, 1'b1);
          rx_q.push_back(d_sh);
          d_busy = 1'b0;
        end
      end
    end
  end

  logic [7:0] sent[$];

  task automatic push_byte(input logic [7:0] d, output int acc_edge);
    int n = 0;
    tx_valid = 1'b1;
    tx_data  = d;
    while (!tx_ready && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("push_ready", tx_ready, 1'b1);
    acc_edge = cyc + 1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(output int at);
    int n = 0;
    while (busy && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", busy, 1'b0);
    at = cyc;
  endtask

  task automatic wait_tx_fall(output int at);
    int n = 0;
    while (tx !== 1'b0 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("tx_fall", tx, 1'b0);
    at = cyc;
  endtask

  task automatic check_rx(input string name);
    check({name, "_count"}, rx_q.size(), sent.size());
    for (int i = 0; i < sent.size(); i++)
      check(name, (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hFFFF_FFFF, 32'(sent[i]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

  logic [9:0] exp54 = 10'b1010101000;
  logic [7:0] burst[6] = '{8'h41, 8'h35, 8'h57, 8'h4E, 8'h46, 8'h51};
  int         acc[6];
  int         a0, a1, f, b, n;

  initial begin
    // Reset
    rst_n = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_ready", tx_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_count", fifo_count, 3'd0);

    // Single byte 0x54
    rx_q.delete();
    sent = '{8'h54};
    push_byte(8'h54, a0);
    wait_tx_fall(f);
    check("latency", f - a0, 1);
    for (int k = 0; k < 10; k++) begin
      repeat ((k == 0) ? CPB / 2 : CPB) @(negedge clk);
      check($sformatf("bit%0d_54", k), tx, exp54[k]);
    end
    wait_idle(b);
    check("busy_len", b - f, FRAME);
    check_rx("rx_single");

    // Burst of six
    rx_q.delete();
    sent.delete();
    tx_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sent.push_back(burst[i]);
      tx_data = burst[i];
      n = 0;
      while (!tx_ready && n < LIMIT) begin
        @(negedge clk);
        n++;
      end
      check("burst_ready", tx_ready, 1'b1);
      acc[i] = cyc + 1;
      @(negedge clk);
    end
    tx_valid = 1'b0;
    for (int i = 1; i < 5; i++) check($sformatf("burst_acc%0d", i), acc[i] - acc[0], i);
    check("burst_acc5", acc[5] - acc[0], FRAME + 2);
    wait_idle(b);
    check("burst_total", b - (acc[0] + 1), 6 * FRAME);
    check_rx("rx_burst");

    // Data changing every cycle while stalled
    rx_q.delete();
    sent.delete();
    tx_valid = 1'b1;
    n = 0;
    while (sent.size() < 6 && n < LIMIT) begin
      tx_data = 8'($urandom);
      if (tx_ready) sent.push_back(tx_data);
      @(negedge clk);
      n++;
    end
    tx_valid = 1'b0;
    check("held_accepts", sent.size(), 6);
    wait_idle(b);
    check_rx("rx_held");

    // Reset during bit 3 of 0x53 with two bytes queued
    push_byte(8'h53, a0);
    push_byte(8'h11, a1);
    push_byte(8'h22, a1);
    f = a0 + 1;
    while (cyc < f + 4 * CPB + CPB / 2) @(negedge clk);
    check("pre_rst_bit3", tx, 1'b0);
    check("pre_rst_count", fifo_count, 3'd2);
    #2 rst_n = 1'b0;
    #1;
    check("async_tx", tx, 1'b1);
    check("async_count", fifo_count, 3'd0);
    check("async_busy", busy, 1'b0);
    rx_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sent = '{8'h46};
    push_byte(8'h46, a0);
    wait_idle(b);
    check_rx("rx_after_rst");

    // Push on the edge that ends STOP while one byte is queued
    rx_q.delete();
    sent = '{8'hA5, 8'h3C, 8'hC3};
    push_byte(8'hA5, a0);
    push_byte(8'h3C, a1);
    f = a0 + 1;
    while (cyc < f + FRAME - 1) @(negedge clk);
    check("pp_pre_count", fifo_count, 3'd1);
    tx_valid = 1'b1;
    tx_data  = 8'hC3;
    @(negedge clk);
    tx_valid = 1'b0;
    check("pp_count", fifo_count, 3'd1);
    check("pp_no_gap", tx, 1'b0);
    wait_idle(b);
    check_rx("rx_pushpop");

    // Randomized traffic
    rx_q.delete();
    sent.delete();
    for (int i = 0; i < 1500; i++) begin
      tx_valid = ($urandom_range(0, 3) == 0);
      tx_data  = 8'($urandom);
      if (tx_valid && tx_ready) sent.push_back(tx_data);
      @(negedge clk);
    end
    tx_valid = 1'b0;
    wait_idle(b);
    check_rx("rx_random");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Byte-serial UART transmitter with a small input FIFO. It is the transmit side of the UART link whose receiver accepts waveform and frequency command bytes. Inside `tt_um_waves` it returns status and echo bytes to the host on a dedicated output pin, using 8N1 framing at the same baud rate as the command receiver.

## Interface
Parameters:
- `CLK_FREQ`, default 25_000_000: system clock frequency in Hz.
- `BAUD`, default 9600: line rate in bit/s.
- `FIFO_DEPTH`, default 4: byte FIFO depth. Must be a power of two, ≥2.
- `CLKS_PER_BIT`, localparam = `CLK_FREQ/BAUD`, integer truncation (2604 at the defaults).

Ports:
- `clk` in 1: single system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `tx_data` in 8: byte to send.
- `tx_valid` in 1: `tx_data` is valid this cycle.
- `tx_ready` out 1: FIFO can accept a byte. A byte is accepted on any edge where `tx_valid && tx_ready`.
- `tx` out 1: serial line, idle high. Driven directly from a flop.
- `busy` out 1: high while a frame is in progress or the FIFO is non-empty.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: number of bytes currently held.

## Operation
- States: IDLE, START, DATA, STOP.
- IDLE, FIFO non-empty:
  - On the edge, pop the head into the 8-bit shift register.
  - Clear the baud counter and enter START. `tx` goes 0 from that edge.
- Baud counter counts 0..CLKS_PER_BIT-1. Each bit period ends on the edge where the counter equals CLKS_PER_BIT-1.
- START end: enter DATA, bit index 0, drive `tx` = shift[0].
- DATA:
  - At the end of each bit, shift right and increment the index.
  - After bit 7 ends, enter STOP and drive `tx` = 1.
- STOP end:
  - FIFO non-empty: pop and go directly to START. No idle gap.
  - FIFO empty: go to IDLE.
- Bits are sent LSB first. A frame is exactly 10·CLKS_PER_BIT cycles.
- FIFO behaviour:
  - `tx_ready = (fifo_count != FIFO_DEPTH)`.
  - A push while full cannot occur, because ready is low.
  - Push and pop on the same edge leave `fifo_count` unchanged and preserve order.
  - A pop never occurs when the FIFO is empty.
- `busy = (state != IDLE) || (fifo_count != 0)`.
- `tx_data` is sampled only on the accept edge. Changes while `tx_ready` is low are ignored.

## Timing
- Reset values: `tx`=1, `tx_ready`=1, `busy`=0, `fifo_count`=0, state IDLE, counters 0.
- Reset asserted mid-frame: `tx` goes to 1 asynchronously, the FIFO is flushed, and the partial frame is dropped. There is no recovery stop bit beyond the idle-high line.
- Latency from the accept edge (FIFO empty, IDLE) to the `tx` falling edge: 1 cycle. The byte is pushed on edge N, popped on edge N+1, and `tx` is low after edge N+1.
- `tx_ready` deasserts the cycle after the FIFO becomes full. It reasserts the cycle after the pop that ends the current frame's STOP.
- `busy` falls on the edge that ends the last STOP bit.

## Structure
- Shared package `waves_pkg` holds:
  - the `uart_tx_state_t` enum (IDLE, START, DATA, STOP);
  - `UART_CLK_FREQ` = 25_000_000 and `UART_BAUD` = 9600, shared with the receiver.
- Sub-module `byte_fifo`: synchronous FIFO with parameter `DEPTH` and ports push, pop, wdata, rdata, count. `rdata` shows the head combinationally.
- The baud counter, bit index, shift register and FSM live in `uart_tx`.

## Test plan
All tests use default parameters. Sample `tx` at mid-bit (offset 1302 cycles) for bit checks.
- **Reset:** hold `rst_n`=0 for 5 cycles, then release → `tx`=1, `tx_ready`=1, `busy`=0, `fifo_count`=0 throughout.
- **Single byte:** push 0x54 → starting 1 cycle after accept, `tx` sequence 0 | 0,0,1,0,1,0,1,0 | 1, each bit 2604 cycles. `busy` falls exactly 26040 cycles after `tx` falls.
- **Burst of six bytes:** hold `tx_valid` with 0x41,0x35,0x57,0x4E,0x46,0x51 advancing on accept → first five accepted on consecutive edges. `tx_ready`=0 while `fifo_count`=4. The sixth is accepted one cycle after the first STOP ends. Six back-to-back frames decode in order, total 156240 cycles, with no idle gap.
- **Held data while stalled:** with the FIFO full, change `tx_data` every cycle while `tx_valid`=1 → only the value present on the accept edge is transmitted.
- **Reset mid-frame:** assert `rst_n`=0 during bit 3 of 0x53 with two bytes queued → `tx`=1 immediately, `fifo_count`=0. Push 0x46 after release → clean frame for 0x46 only.
- **Simultaneous push/pop:** push a byte on the exact edge the STOP bit ends while the FIFO holds 1 byte → `fifo_count` stays 1 and the next frame starts with no gap.
